vx_commit_sched: RTL
====================

Name: vx_commit_sched

Overview:
- Per-issue-slot commit scheduler. Shares one commit path between NUM_REQS execution-unit sources (ALU, LSU, FPU, SFU, ...) ahead of the commit gather stage.
- Arbitration is round-robin and packet-atomic: once a multi-packet commit (sop..eop) starts, the grant is held on that source until its eop beat is accepted.
- The output is registered (1-cycle latency) with full-throughput valid/ready handshake.

Parameters:
- NUM_REQS, 4, number of requesting commit sources (>=1).
- DATAW, 64, width of the commit payload. Bit [1] = sop, bit [0] = eop; other bits opaque.
- PERF_CTR_BITS, 44, width of performance counters (optional feature only).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  NUM_REQS  per-source commit valid
- req_data  input  NUM_REQS*DATAW  per-source payload, source i at [i*DATAW +: DATAW]
- req_ready  output  NUM_REQS  per-source accept
- out_valid  output  1  registered commit valid
- out_data  output  DATAW  registered commit payload
- out_ready  input  1  downstream accept
- out_sel  output  LOG2UP(NUM_REQS)  source index of the current out_data
- perf_stalls  output  PERF_CTR_BITS  present only with VX_COMMIT_SCHED_PERF_EN
- perf_conflicts  output  PERF_CTR_BITS  present only with VX_COMMIT_SCHED_PERF_EN

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0, state=IDLE, lock_idx=0, perf counters=0.
  - Reset mid-packet drops the lock; no partial state survives.
- Pipe register enable: en = !out_valid || out_ready. When en=0, all req_ready=0 and the register holds.
- Eligibility:
  - IDLE: all i with req_valid[i].
  - LOCKED: only i == lock_idx.
- Grant:
  - IDLE: first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQS.
  - LOCKED: lock_idx if req_valid[lock_idx].
  - req_ready[g] = en && grant_valid; every other req_ready bit = 0. Combinational from req_valid, state and en; never from req_data.
- Handshake fire (req_valid[g] && req_ready[g]): next cycle out_valid=1, out_data=req_data[g], out_sel=g.
- If en=1 and nothing fires: out_valid <= 0.
- State transitions, evaluated on fire only:
  - IDLE & sop=1 & eop=0 -> LOCKED, lock_idx=g.
  - IDLE & eop=1 -> stay IDLE, rr_ptr = g+1 (mod NUM_REQS).
  - LOCKED & eop=1 -> IDLE, rr_ptr = lock_idx+1 (mod NUM_REQS).
  - LOCKED & eop=0 -> stay LOCKED.
  - IDLE & sop=0 & eop=0: protocol error, treated as a lock start (-> LOCKED). Simulation-only assertion flags it.
- Wrap-around: rr_ptr increments from NUM_REQS-1 to 0. NUM_REQS=1 is a degenerate pass-through with the same 1-cycle latency.
- Simultaneous events:
  - out_ready=1 with a new fire in the same cycle: the register reloads with no bubble (100% throughput).
  - A locked source with no valid beat stalls the whole path; other sources wait (no timeout).
- Packets from different sources never interleave on out_data.
- Latency: exactly 1 cycle from fire to out_valid.

Optional Feature:
- Macro: VX_COMMIT_SCHED_PERF_EN.
- Defined: two saturating counters, both cleared by reset.
  - perf_stalls: +1 each cycle where |req_valid && no fire.
  - perf_conflicts: +1 each cycle where popcount(req_valid) >= 2 and a fire occurs.
- Undefined: ports and counter logic are absent. Datapath timing and behaviour are identical either way.

Test Plan:
- Reset with all req_valid=1 -> req_ready=0 during reset; after reset deassert with out_ready=1: grant order 0,1,2,3,0 (single-beat sop=eop=1), out_valid high every cycle from cycle 1.
- Source 2 sends a 3-beat packet (sop=1/eop=0, 0/0, 0/1) while sources 0,1,3 are valid -> out_sel=2 for 3 consecutive beats, then next grant=3, rr_ptr=3.
- out_ready=0 for 5 cycles with out_valid=1, data=0xA5 -> out_data stays 0xA5, all req_ready=0; on out_ready=1 the next beat loads the same cycle with no bubble.
- Locked on source 1, then req_valid[1]=0 for 4 cycles while source 0 is valid -> no fire, out_valid drops to 0 after drain, req_ready[0]=0; with PERF_EN, perf_stalls=4.
- Reset asserted mid-packet on source 3 -> state=IDLE, rr_ptr=0; the first post-reset grant goes to source 0 if valid.
- NUM_REQS=1: a stream of 8 beats with out_ready always 1 -> 8 outputs, 1-cycle latency each, out_sel always 0.

Source files
------------

// File: rtl/vx_commit_sched.sv
// rtl/vx_commit_sched.sv - round-robin, packet-atomic commit scheduler with a registered output
// Optional stall/conflict counters: define VX_COMMIT_SCHED_PERF_EN.
module vx_commit_sched #(
  parameter int NUM_REQS      = 4,
  parameter int DATAW         = 64,
  parameter int PERF_CTR_BITS = 44,
  localparam int SELW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef VX_COMMIT_SCHED_PERF_EN
  output logic [PERF_CTR_BITS-1:0]  perf_stalls,
  output logic [PERF_CTR_BITS-1:0]  perf_conflicts,
`endif
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  if (NUM_REQS < 1 || DATAW < 2 || PERF_CTR_BITS < 1) begin : g_bad_cfg
    $error("vx_commit_sched: invalid parameter set");
  end

  state_e           state_q, state_d;
  logic [SELW-1:0]  lock_idx_q, lock_idx_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;

  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    scan_idx;
  logic [DATAW-1:0] grant_data;
  logic             en;
  logic             fire;

  function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
    return (idx == SELW'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin scan starts at rr_ptr; a held lock overrides it entirely.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    if (state_q == ST_LOCKED) begin
      grant_valid = req_valid[lock_idx_q];
      grant_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (scan_idx >= (SELW+1)'(NUM_REQS)) begin
          scan_idx = scan_idx - (SELW+1)'(NUM_REQS);
        end
        if (!grant_valid && req_valid[scan_idx[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx[SELW-1:0];
        end
      end
    end
  end

  assign en         = (!out_valid_q || out_ready) && !reset;
  assign fire       = en && grant_valid;
  assign grant_data = req_data[int'(grant_idx)*DATAW +: DATAW];

  always_comb begin
    req_ready            = '0;
    req_ready[grant_idx] = fire;
  end

  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      // A headless beat in IDLE (sop=0, eop=0) is treated as a lock start.
      if (state_q == ST_IDLE) begin
        if (grant_data[0]) begin
          rr_ptr_d = next_idx(grant_idx);
        end else begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant_idx;
        end
      end else if (grant_data[0]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_idx(lock_idx_q);
      end
    end else if (en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef VX_COMMIT_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls_q, perf_stalls_d;
  logic [PERF_CTR_BITS-1:0] perf_conflicts_q, perf_conflicts_d;

  always_comb begin
    perf_stalls_d    = perf_stalls_q;
    perf_conflicts_d = perf_conflicts_q;
    if ((|req_valid) && !fire && (perf_stalls_q != '1)) begin
      perf_stalls_d = perf_stalls_q + 1'b1;
    end
    if (($countones(req_valid) >= 2) && fire && (perf_conflicts_q != '1)) begin
      perf_conflicts_d = perf_conflicts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_stalls_q    <= perf_stalls_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_stalls    = perf_stalls_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

`ifndef SYNTHESIS
  a_no_headless_beat: assert property (@(posedge clk) disable iff (reset)
    (fire && state_q == ST_IDLE) |-> (grant_data[1] || grant_data[0]));
`endif

endmodule
